// File: rtl/mci_memory_responder.sv
// mci_memory_responder: main-memory model at the responder end of the memory
// controller interface. It accepts one block-sized read/write request at a
// time, services it from an internal block-addressed store, and returns a
// single-cycle ready pulse with the block data after a latency.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   mem_req  in   mci_request_t  {valid, rw (1=write), addr (byte), data}
//   mem_res  out  mci_response_t {ready, data}, both registered
//
// Optional feature macro: MCI_MEM_RANDLAT_EN
//   defined   -> per-request latency from a 16-bit LFSR, 1..LATENCY
//   undefined -> latency fixed at LATENCY, no LFSR logic

package memory_controller_interface;
  localparam int unsigned MCI_DATA_LENGTH = 128;
  localparam int unsigned MCI_ADDR_LENGTH = 32;

  typedef struct packed {
    logic                       valid;
    logic                       rw;
    logic [MCI_ADDR_LENGTH-1:0] addr;
    logic [MCI_DATA_LENGTH-1:0] data;
  } mci_request_t;

  typedef struct packed {
    logic                       ready;
    logic [MCI_DATA_LENGTH-1:0] data;
  } mci_response_t;
endpackage

module mci_memory_responder
  import memory_controller_interface::*;
#(
  parameter int unsigned DEPTH   = 65536,
  parameter int unsigned LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  mci_request_t  mem_req,
  output mci_response_t mem_res
);

  localparam int unsigned OFFSET_BITS = $clog2(MCI_DATA_LENGTH / 8);
  localparam int unsigned IDX_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx_q;
  logic [MCI_DATA_LENGTH-1:0] store [DEPTH];

  logic                       accept_c;
  logic [IDX_W-1:0]           req_idx_c;
  logic [CNT_W-1:0]           lat_c;
  logic                       unused_addr_c;

  // New requests are taken only when idle or in the response cycle.
  assign accept_c      = mem_req.valid && (state == IDLE || state == RESP);
  assign req_idx_c     = mem_req.addr[OFFSET_BITS +: IDX_W];
  assign unused_addr_c = ^mem_req.addr;

`ifdef MCI_MEM_RANDLAT_EN
  logic [15:0] lfsr;

  // Galois LFSR, stepped once per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (accept_c) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign lat_c = CNT_W'((32'(lfsr) % LATENCY) + 32'd1);
`else
  assign lat_c = CNT_W'(LATENCY);
`endif

  // Writes commit at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && accept_c && mem_req.rw) begin
      store[req_idx_c] <= mem_req.data;
    end
  end

  // Request/response sequencing with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      mem_res      <= '0;
    end else begin
      mem_res.ready <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept_c) begin
            idx_q <= req_idx_c;
            if (lat_c == CNT_W'(1)) begin
              // Single-cycle latency: forward write data past the store.
              state         <= RESP;
              mem_res.ready <= 1'b1;
              mem_res.data  <= mem_req.rw ? mem_req.data : store[req_idx_c];
            end else begin
              state <= WAIT;
              cnt   <= lat_c - CNT_W'(2);
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= RESP;
            mem_res.ready <= 1'b1;
            mem_res.data  <= store[idx_q];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mci_memory_responder.sv
module tb_mci_memory_responder;
  import memory_controller_interface::*;

  localparam int unsigned L0 = 4;
  localparam int unsigned D0 = 65536;
  localparam int unsigned L1 = 1;
  localparam int unsigned D1 = 16;

  typedef struct {
    logic [127:0] data;
    bit           chk;
    int           due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst0, rst1;
  mci_request_t  req0, req1;
  mci_response_t res0, res1;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [127:0] m0 [int];
  logic [127:0] m1 [int];
  int           free0 = 0, free1 = 0;
  int           cyc = 0;
  int           checks = 0, errors = 0;
  bit           prev0 = 1'b0;

  mci_memory_responder #(.DEPTH(D0), .LATENCY(L0)) dut0 (
    .clk(clk), .rst(rst0), .mem_req(req0), .mem_res(res0));
  mci_memory_responder #(.DEPTH(D1), .LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst1), .mem_req(req1), .mem_res(res1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int blk(int d, logic [31:0] a);
    return int'((a >> 4) % ((d == 0) ? D0 : D1));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of stimulus (called at negedge+2) and update the
  // reference model: the responder is free once the previous response cycle
  // has been reached; requests arriving earlier are dropped.
  task automatic step(int d, bit v, bit rw, logic [31:0] a, logic [127:0] dat, bit rs);
    mci_request_t r;
    exp_t x;
    int e, i, lat, fr;
    r.valid = v; r.rw = rw; r.addr = a; r.data = dat;
    req0.valid = 1'b0; req1.valid = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
    if (d == 0) begin req0 = r; rst0 = rs; end
    else begin req1 = r; rst1 = rs; end
    e   = cyc + 1;
    i   = blk(d, a);
    lat = (d == 0) ? int'(L0) : int'(L1);
    fr  = (d == 0) ? free0 : free1;
    if (rs) begin
      if (d == 0) begin q0.delete(); free0 = 0; end
      else begin q1.delete(); free1 = 0; end
    end else if (v && e >= fr) begin
      x.due = e + lat - 1;
      x.chk = 1'b1;
      if (rw) begin
        x.data = dat;
        if (d == 0) m0[i] = dat; else m1[i] = dat;
      end else if (d == 0 && m0.exists(i)) x.data = m0[i];
      else if (d == 1 && m1.exists(i)) x.data = m1[i];
      else begin x.data = '0; x.chk = 1'b0; end
      if (d == 0) begin q0.push_back(x); free0 = e + lat; end
      else begin q1.push_back(x); free1 = e + lat; end
    end
    @(negedge clk);
    #2;
  endtask

  task automatic idle(int d);
    step(d, 1'b0, 1'b0, 32'h0, 128'h0, 1'b0);
  endtask

  task automatic wait_free(int d);
    while (cyc + 1 < ((d == 0) ? free0 : free1)) idle(d);
  endtask

  task automatic check_quiet(string name);
    checks++;
    if (res0.ready !== 1'b0 || res0.data !== 128'h0) begin
      errors++;
      $display("FAIL %s cyc=%0d ready=%b data=%h want ready=0 data=0",
               name, cyc, res0.ready, res0.data);
    end
  endtask

  // Scoreboard monitor: compare each ready pulse against the queue head.
  task automatic mon(int d, logic rdy, logic [127:0] dat);
    exp_t h;
    bit have;
    if (d == 0 && rdy) begin
      checks++;
      if (prev0) begin
        errors++;
        $display("FAIL ready_twice dut0 cyc=%0d ready high two cycles in a row", cyc);
      end
    end
    if (d == 0) prev0 = rdy;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) h = (d == 0) ? q0[0] : q1[0];
    if (have && h.due < cyc) begin
      checks++; errors++;
      $display("FAIL missing_ready dut%0d cyc=%0d no ready, want ready at cyc=%0d", d, cyc, h.due);
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) h = (d == 0) ? q0[0] : q1[0];
    end
    if (rdy) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_ready dut%0d cyc=%0d ready=1 want 0", d, cyc);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (h.due != cyc) begin
          errors++;
          $display("FAIL ready_timing dut%0d ready at cyc=%0d want cyc=%0d", d, cyc, h.due);
        end
        if (h.chk) begin
          checks++;
          if (dat !== h.data) begin
            errors++;
            $display("FAIL read_data dut%0d cyc=%0d got %h want %h", d, cyc, dat, h.data);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, res0.ready, res0.data);
    mon(1, res1.ready, res1.data);
  end

  initial begin
    logic [31:0]  a;
    logic [127:0] dead;
    dead = 128'hDEAD_C0DE_0123_4567_89AB_CDEF_F00D_BEEF;
    req0 = '0; req1 = '0; rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;

    // Quiet after reset.
    for (int k = 0; k < 10; k++) begin
      idle(0);
      check_quiet("reset_idle");
    end

    // Write then same-block read.
    step(0, 1'b1, 1'b1, 32'h0000_1230, dead, 1'b0);
    wait_free(0);
    step(0, 1'b1, 1'b0, 32'h0000_123C, rnd128(), 1'b0);
    wait_free(0);

    // Write-back then refill issued in the ready cycle.
    step(0, 1'b1, 1'b1, 32'h0002_0000, rnd128(), 1'b0);
    wait_free(0);
    step(0, 1'b1, 1'b1, 32'h0001_0000, rnd128(), 1'b0);
    wait_free(0);
    step(0, 1'b1, 1'b0, 32'h0002_0000, 128'h0, 1'b0);
    wait_free(0);

    // Write pulsed during WAIT is dropped.
    step(0, 1'b1, 1'b1, 32'h0000_0040, rnd128(), 1'b0);
    wait_free(0);
    step(0, 1'b1, 1'b0, 32'h0000_0080, 128'h0, 1'b0);
    step(0, 1'b1, 1'b1, 32'h0000_0040, rnd128(), 1'b0);
    wait_free(0);
    step(0, 1'b1, 1'b0, 32'h0000_0040, 128'h0, 1'b0);
    wait_free(0);

    // Reset during WAIT of a read; valid alongside rst is ignored.
    step(0, 1'b1, 1'b0, 32'h0000_1230, 128'h0, 1'b0);
    idle(0);
    step(0, 1'b1, 1'b1, 32'h0000_1230, rnd128(), 1'b1);
    check_quiet("after_rst");
    for (int k = 0; k < 6; k++) idle(0);
    step(0, 1'b1, 1'b0, 32'h0000_1230, 128'h0, 1'b0);
    wait_free(0);

    // Randomized traffic with aliasing high address bits.
    for (int k = 0; k < 500; k++) begin
      a = ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, 7)) << 4) | ($urandom & 32'hF);
      step(0, ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1, a, rnd128(), 1'b0);
    end
    wait_free(0);

    // Single-cycle latency, small store: wrap-around then back-to-back traffic.
    step(1, 1'b1, 1'b1, 32'(16 * 16), rnd128(), 1'b0);
    step(1, 1'b1, 1'b0, 32'h0, 128'h0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      step(1, ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, $urandom, rnd128(), 1'b0);
    end

    for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++) idle(0);
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q0.size() + q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mci_memory_responder.md
# mci_memory_responder

Responder end of the memory controller interface: accepts block-sized read/write requests issued by the data cache on `mem_req`, services them from an internal block-addressed backing store after a configurable latency, and returns a one-cycle `mem_res.ready` pulse carrying the block data. It sits below `dcache_dm1cycle` in simulation and FPGA builds as the main-memory model, and uses the `memory_controller_interface` package types unchanged.

## Interface
- `DEPTH`, 65536: backing store capacity in blocks; power of two.
- `LATENCY`, 4: cycles from request acceptance to `ready`; must be ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  in  `mci_request_t`  request from cache: `valid`, `rw` (1 = write), `addr` (byte address), `data` (`MCI_DATA_LENGTH` bits).
- `mem_res`  out  `mci_response_t`  response to cache: `ready`, `data` (`MCI_DATA_LENGTH` bits).

## Operation
- Block index = `addr[OFFSET_BITS +: $clog2(DEPTH)]`, `OFFSET_BITS = $clog2(MCI_DATA_LENGTH/8)`. Offset bits ignored; address bits above the index ignored (aliasing wrap-around, no error).
- One outstanding request at a time. FSM states:
  - IDLE: `ready`=0. `valid`=1 at an edge → accept: latch index and `rw`; if `rw`=1 write `data` into store at that same edge. Load latency counter; go WAIT (or RESP if `LATENCY`=1).
  - WAIT: count down; `valid` ignored (request is dropped, never serviced). When count expires go RESP.
  - RESP: `ready`=1 for exactly one cycle; `data` = store contents at latched index (for writes, the block just written). `valid`=1 during RESP is accepted exactly as in IDLE (back-to-back; required because the cache issues its refill read in the same cycle it sees the write-back `ready`). Otherwise go IDLE.
- Request fields are sampled only at acceptance; later changes of `addr`/`data`/`rw` have no effect.
- Store contents are not reset; uninitialised blocks read X in simulation.
- Write-then-read to the same block returns the new data (write commits at acceptance, before any later read).

## Timing
- Request accepted at edge N → `ready` high during cycle N+`LATENCY`, low at all other times.
- Back-to-back throughput: one request per `LATENCY` cycles (acceptance edge of request k+1 = edge ending RESP of request k).
- `mem_res.ready` and `mem_res.data` are registered outputs; no combinational path from `mem_req`.
- Reset values: `ready`=0, `data`='0, state IDLE, counter 0.
- `rst` asserted mid-request: pending response discarded, no `ready` pulse after reset; a write already accepted remains committed. `valid` in the same cycle as `rst` is ignored.

## Configuration
- `MCI_MEM_RANDLAT_EN` defined: per-request latency drawn from a 16-bit LFSR (seed 16'hACE1, reseeded on `rst`), uniform-ish in 1..`LATENCY`; LFSR advances once per accepted request. All ordering and single-pulse rules unchanged.
- Not defined: latency fixed at exactly `LATENCY`; no LFSR logic compiled.

## Test plan
- Reset then idle 10 cycles, `valid`=0 → `ready`=0, `data`=0 throughout.
- `LATENCY`=4: write block 128'hDEAD…BEEF to addr 0x0000_1230, edge N → `ready`=1 only in cycle N+4 with data 128'hDEAD…BEEF; read of 0x0000_123C (same block) → returns same data 4 cycles after its acceptance.
- Write-back then refill: write to 0x0001_0000 accepted, `valid`+read of 0x0002_0000 asserted in the `ready` cycle → read accepted, second `ready` exactly 4 cycles later with 0x0002_0000 contents; no cycle with `ready` high twice in a row.
- `valid` pulsed during WAIT with a write to 0x40 → ignored: block 0x40 unchanged, only one `ready` produced.
- `rst` asserted in WAIT of a read → no `ready` after reset; a subsequent read completes normally at +`LATENCY`.
- `LATENCY`=1, `DEPTH`=16: write to addr 16×block size (wraps to index 0), read index 0 → returns written data, `ready` one cycle after each acceptance; with `MCI_MEM_RANDLAT_EN` and `LATENCY`=8, 1000 requests → every latency in 1..8, all data correct.
